sync_bank: RTL and testbench
============================

Name: sync_bank

Overview:
- Parametrised multi-channel input conditioner. It is the successor to the single-bit level/pulse synchroniser.
- Brings WIDTH asynchronous inputs into the clk domain through a configurable-depth flop chain, then an optional per-channel debounce filter.
- Produces a clean level, a per-channel selectable edge pulse, and a sticky event flag with software clear.
- Sits at the boundary between pins or foreign-domain levels and the destination-domain control logic.

Parameters:
- WIDTH, 8: number of independent channels (>=1).
- STAGES, 2: synchroniser flops per channel (>=2).
- FILT_CNT, 0: debounce length in clk cycles; 0 = filter bypassed.
- CNT_W, $clog2(FILT_CNT+1) (min 1): width of the filter counter. Derived; do not override.

Ports:
- clk  in  1  destination clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- async_in  in  WIDTH  asynchronous inputs, one per channel.
- mode  in  2*WIDTH  per-channel edge select; bits [2i+1:2i] belong to channel i.
- sticky_clr  in  WIDTH  per-channel clear for sticky_out.
- level_out  out  WIDTH  synchronised, filtered level.
- pulse_out  out  WIDTH  one-cycle edge pulse per channel.
- sticky_out  out  WIDTH  latched event flag per channel.

Behaviour:
- One clock; reset is synchronous and active-high. Every flop samples rst on the rising edge of clk.
- Reset values: sync chain, filter state, filter counters, filt_d and sticky are all 0. level_out, pulse_out and sticky_out therefore all read 0 during and after reset.

Synchroniser:
- Per channel: sync[0] <= async_in[i], then sync[k] <= sync[k-1]. sy = sync[STAGES-1].
- No logic between chain flops; the chain carries the synchroniser attribute.

Filter, FILT_CNT = 0:
- filt = sy (wire). No counter is instantiated.

Filter, FILT_CNT = N > 0 (per channel: register filt, counter cnt):
- sy == filt: cnt <= 0.
- sy != filt and cnt < N-1: cnt <= cnt+1.
- sy != filt and cnt == N-1: filt <= sy, cnt <= 0.
- Result: a sy change held for N consecutive cycles updates filt N edges later. Any sy excursion shorter than N cycles is rejected and the counter restarts from 0.

Outputs:
- level_out = filt.
- filt_d <= filt every cycle.
- rise = filt & ~filt_d; fall = ~filt & filt_d.
- pulse_out by mode: 00 (LEVEL) = 0, 01 (RISE) = rise, 10 (FALL) = fall, 11 (ANY) = rise | fall.
- pulse_out is exactly 1 cycle wide and asserts in the same cycle that level_out first shows the new value.
- Latency from async_in change to level_out/pulse_out: STAGES+FILT_CNT edges, plus up to 1 cycle of sampling uncertainty.

Sticky:
- sticky <= (sticky & ~sticky_clr) | pulse_out.
- When set and clear coincide, set wins: the flag stays 1.
- sticky_out is the register output, so it rises 1 cycle after pulse_out.

Mode changes:
- mode is quasi-static but may change at any time; it is applied combinationally to pulse_out.
- A mode change never creates a pulse by itself; a pulse needs filt != filt_d.

Boundary conditions:
- Input high across reset release: presented as a 0->1 transition, giving a RISE pulse STAGES+FILT_CNT cycles after rst deasserts. This is intended.
- Reset mid-filter: the counter and filt clear, and any pending transition is lost.
- Input toggling every cycle with FILT_CNT >= 2: level_out never changes.
- Channels are fully independent; there is no cross-channel ordering guarantee.

Decomposition:
- Shared package sync_pkg holds:
  - MODE_LEVEL = 2'b00, MODE_RISE = 2'b01, MODE_FALL = 2'b10, MODE_ANY = 2'b11;
  - the typedef sync_mode_t (logic [1:0]).
- One sub-module, sync_chan: a single channel covering chain, filter, edge detect and sticky, with parameters STAGES and FILT_CNT.
- sync_bank is a generate loop of WIDTH sync_chan instances plus port slicing.

Test Plan:
- Reset and release, STAGES=2, FILT_CNT=0, async_in=0 -> all outputs 0. Then drive ch0 high -> level_out[0]=1 two edges later, pulse_out[0] high 1 cycle with mode=RISE, sticky_out[0]=1 the following cycle.
- FILT_CNT=4, 3-cycle high glitch on ch1 -> level_out[1] and pulse_out[1] stay 0. Then a 6-cycle high on ch1 -> level_out[1] rises at edge STAGES+4 after the input change.
- mode per channel = LEVEL/RISE/FALL/ANY on ch0-3, each with a high pulse of 10 cycles -> pulse counts 0/1/1/2, each pulse exactly 1 cycle wide.
- Sticky: pulse and sticky_clr in the same cycle -> sticky_out stays 1. sticky_clr alone next cycle -> 0. Clear with no pulse -> stays 0.
- Input held 1 through reset, STAGES=3, FILT_CNT=2 -> RISE pulse exactly 5 cycles after rst falls. Then assert rst mid-filter -> all outputs 0 on the next edge and no pulse appears on release while the input is 0.
- Random async_in across WIDTH=8 with randomised STAGES and FILT_CNT; a reference model checks level_out, pulse_out and sticky_out cycle-exact per channel.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared definitions for the sync_bank input conditioner.
//   sync_mode_t : per-channel edge select encoding
//   edge_sel()  : maps mode plus rise/fall strobes onto the pulse output
package sync_pkg;

   typedef logic [1:0] sync_mode_t;

   localparam sync_mode_t MODE_LEVEL = 2'b00;
   localparam sync_mode_t MODE_RISE  = 2'b01;
   localparam sync_mode_t MODE_FALL  = 2'b10;
   localparam sync_mode_t MODE_ANY   = 2'b11;

   // Select which edge(s) of the filtered level produce a pulse.
   function automatic logic edge_sel(input sync_mode_t mode,
                                     input logic       rise,
                                     input logic       fall);
      logic r;
      r = 1'b0;
      case (mode)
         MODE_RISE: r = rise;
         MODE_FALL: r = fall;
         MODE_ANY:  r = rise | fall;
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sync_chan.sv
// One conditioner channel: synchroniser chain, optional debounce filter,
// edge detect and sticky event flag.
//   clk, rst     : destination clock, synchronous active-high reset
//   i_async      : asynchronous input
//   i_mode       : edge select for o_pulse_c
//   i_sticky_clr : clear for the sticky flag (a coincident pulse wins)
//   o_level      : synchronised, filtered level
//   o_pulse_c    : one-cycle edge pulse (combinational on i_mode)
//   o_sticky     : latched event flag
module sync_chan
   import sync_pkg::*;
#(
   parameter int unsigned STAGES   = 2,
   parameter int unsigned FILT_CNT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_async,
   input  sync_mode_t i_mode,
   input  logic       i_sticky_clr,
   output logic       o_level,
   output logic       o_pulse_c,
   output logic       o_sticky
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;
   logic w_sy;
   logic w_filt;
   logic r_filt_d;
   logic r_sticky;
   logic w_rise;
   logic w_fall;
   logic w_pulse;

   // Plain flop chain; nothing may sit between the stages.
   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[STAGES-2:0], i_async};
   end

   assign w_sy = r_sync[STAGES-1];

   if (FILT_CNT == 0) begin : g_bypass
      assign w_filt = w_sy;
   end else begin : g_filt
      localparam int unsigned CNT_W = $clog2(FILT_CNT + 1);
      logic             r_filt;
      logic [CNT_W-1:0] r_cnt;

      // Accept a new level only after FILT_CNT consecutive disagreeing samples.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
         end else if (w_sy == r_filt) begin
            r_cnt  <= '0;
         end else if (r_cnt == CNT_W'(FILT_CNT - 1)) begin
            r_filt <= w_sy;
            r_cnt  <= '0;
         end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
         end
      end

      assign w_filt = r_filt;
   end

   // Edge detect and sticky flag; set has priority over clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt_d <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         r_filt_d <= w_filt;
         r_sticky <= (r_sticky & ~i_sticky_clr) | w_pulse;
      end
   end

   assign w_rise  = w_filt & ~r_filt_d;
   assign w_fall  = ~w_filt & r_filt_d;
   assign w_pulse = edge_sel(i_mode, w_rise, w_fall);

   assign o_level   = w_filt;
   assign o_pulse_c = w_pulse;
   assign o_sticky  = r_sticky;

endmodule

// File: rtl/sync_bank.sv
// Multi-channel input conditioner: WIDTH independent sync_chan instances.
//   clk, rst   : destination clock, synchronous active-high reset
//   async_in   : asynchronous inputs, one per channel
//   mode       : edge select, bits [2i+1:2i] for channel i
//   sticky_clr : per-channel sticky clear
//   level_out  : synchronised, filtered levels
//   pulse_out  : one-cycle edge pulses
//   sticky_out : latched event flags
module sync_bank
   import sync_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned STAGES   = 2,
   parameter int unsigned FILT_CNT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   async_in,
   input  logic [2*WIDTH-1:0] mode,
   input  logic [WIDTH-1:0]   sticky_clr,
   output logic [WIDTH-1:0]   level_out,
   output logic [WIDTH-1:0]   pulse_out,
   output logic [WIDTH-1:0]   sticky_out
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      sync_chan #(
         .STAGES   (STAGES),
         .FILT_CNT (FILT_CNT)
      ) u_chan (
         .clk          (clk),
         .rst          (rst),
         .i_async      (async_in[i]),
         .i_mode       (sync_mode_t'(mode[2*i +: 2])),
         .i_sticky_clr (sticky_clr[i]),
         .o_level      (level_out[i]),
         .o_pulse_c    (pulse_out[i]),
         .o_sticky     (sticky_out[i])
      );
   end

endmodule

// File: tb/tb_sync_bank.sv
// Self-checking bench for sync_bank: four instances with different
// STAGES/FILT_CNT share one stimulus stream; a history-based reference model
// predicts every output every cycle, plus directed scenario checks.
module tb_sync_bank;
   import sync_pkg::*;

   localparam int W  = 8;
   localparam int ND = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   async_in;
   logic [2*W-1:0] mode;
   logic [W-1:0]   sticky_clr;
   logic [W-1:0]   lv [ND];
   logic [W-1:0]   pl [ND];
   logic [W-1:0]   st [ND];

   always #5 clk = ~clk;

   sync_bank #(.WIDTH(W), .STAGES(2), .FILT_CNT(0)) u0 (
      .clk(clk), .rst(rst), .async_in(async_in), .mode(mode), .sticky_clr(sticky_clr),
      .level_out(lv[0]), .pulse_out(pl[0]), .sticky_out(st[0]));
   sync_bank #(.WIDTH(W), .STAGES(2), .FILT_CNT(4)) u1 (
      .clk(clk), .rst(rst), .async_in(async_in), .mode(mode), .sticky_clr(sticky_clr),
      .level_out(lv[1]), .pulse_out(pl[1]), .sticky_out(st[1]));
   sync_bank #(.WIDTH(W), .STAGES(3), .FILT_CNT(2)) u2 (
      .clk(clk), .rst(rst), .async_in(async_in), .mode(mode), .sticky_clr(sticky_clr),
      .level_out(lv[2]), .pulse_out(pl[2]), .sticky_out(st[2]));
   sync_bank #(.WIDTH(W), .STAGES(4), .FILT_CNT(1)) u3 (
      .clk(clk), .rst(rst), .async_in(async_in), .mode(mode), .sticky_clr(sticky_clr),
      .level_out(lv[3]), .pulse_out(pl[3]), .sticky_out(st[3]));

   int checks = 0;
   int fails  = 0;

   // Model state: input sample history (bit 0 newest), filtered level,
   // previous filtered level and sticky flag per instance and channel.
   bit [31:0] ah  [ND][W];
   bit        mf  [ND][W];
   bit        mfd [ND][W];
   bit        mst [ND][W];

   function automatic int s_of(int d);
      case (d)
         0: return 2;
         1: return 2;
         2: return 3;
         default: return 4;
      endcase
   endfunction

   function automatic int n_of(int d);
      case (d)
         0: return 0;
         1: return 4;
         2: return 2;
         default: return 1;
      endcase
   endfunction

   function automatic bit mpulse(logic [1:0] m, bit f, bit fd);
      bit rise;
      bit fall;
      rise = f && !fd;
      fall = !f && fd;
      if (m == MODE_RISE)      return rise;
      else if (m == MODE_FALL) return fall;
      else if (m == MODE_ANY)  return rise || fall;
      return 1'b0;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: advance the model by the rules, then compare every output.
   task automatic step();
      bit pp [ND][W];
      logic [W-1:0] el, ep, es;
      for (int d = 0; d < ND; d++)
         for (int c = 0; c < W; c++)
            pp[d][c] = mpulse(mode[2*c +: 2], mf[d][c], mfd[d][c]);
      @(posedge clk);
      for (int d = 0; d < ND; d++) begin
         for (int c = 0; c < W; c++) begin
            if (rst) begin
               ah[d][c] = '0; mf[d][c] = 1'b0; mfd[d][c] = 1'b0; mst[d][c] = 1'b0;
            end else begin
               bit [31:0] h;
               bit nf;
               h = {ah[d][c][30:0], async_in[c]};
               if (n_of(d) == 0) begin
                  nf = h[s_of(d)-1];
               end else begin
                  // Flip only if the last N synchronised samples all disagree.
                  nf = !mf[d][c];
                  for (int j = 0; j < n_of(d); j++)
                     if (h[s_of(d)+j] == mf[d][c]) nf = mf[d][c];
               end
               mst[d][c] = (mst[d][c] && !sticky_clr[c]) || pp[d][c];
               mfd[d][c] = mf[d][c];
               mf[d][c]  = nf;
               ah[d][c]  = h;
            end
         end
      end
      #1;
      for (int d = 0; d < ND; d++) begin
         el = '0; ep = '0; es = '0;
         for (int c = 0; c < W; c++) begin
            el[c] = mf[d][c];
            ep[c] = mpulse(mode[2*c +: 2], mf[d][c], mfd[d][c]);
            es[c] = mst[d][c];
         end
         check($sformatf("model_level_d%0d", d),  32'(lv[d]), 32'(el));
         check($sformatf("model_pulse_d%0d", d),  32'(pl[d]), 32'(ep));
         check($sformatf("model_sticky_d%0d", d), 32'(st[d]), 32'(es));
      end
   endtask

   int first;
   int pcnt;
   bit seen;
   int pc [ND][4];
   int ps [ND][4];
   bit prev [ND][4];
   int exp_pulses [4];

   initial begin
      rst        = 1'b1;
      async_in   = '0;
      sticky_clr = '0;
      mode       = {W{MODE_RISE}};
      exp_pulses = '{0, 1, 1, 2};

      // Reset state.
      repeat (3) step();
      for (int d = 0; d < ND; d++) begin
         check($sformatf("rst_level_d%0d", d),  32'(lv[d]), 32'h0);
         check($sformatf("rst_pulse_d%0d", d),  32'(pl[d]), 32'h0);
         check($sformatf("rst_sticky_d%0d", d), 32'(st[d]), 32'h0);
      end
      rst = 1'b0;
      repeat (2) step();

      // ch0 rise through a 2-stage chain without filter.
      async_in[0] = 1'b1;
      step();
      check("ch0_lat_edge1", 32'(lv[0][0]), 32'h0);
      step();
      check("ch0_level",      32'(lv[0][0]), 32'h1);
      check("ch0_pulse",      32'(pl[0][0]), 32'h1);
      check("ch0_sticky_pre", 32'(st[0][0]), 32'h0);
      step();
      check("ch0_pulse_width", 32'(pl[0][0]), 32'h0);
      check("ch0_sticky",      32'(st[0][0]), 32'h1);
      async_in[0] = 1'b0;
      repeat (12) step();

      // 3-cycle glitch on ch1 is rejected by the 4-cycle filter.
      seen = 1'b0;
      async_in[1] = 1'b1;
      for (int k = 0; k < 15; k++) begin
         if (k == 3) async_in[1] = 1'b0;
         step();
         seen = seen | lv[1][1] | pl[1][1];
      end
      check("ch1_glitch_rejected", 32'(seen), 32'h0);

      // 6-cycle high passes, level rises STAGES+FILT_CNT edges later.
      first = -1;
      async_in[1] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (first < 0 && lv[1][1] === 1'b1) first = k;
         if (k == 6) check("ch1_filt_pulse", 32'(pl[1][1]), 32'h1);
      end
      async_in[1] = 1'b0;
      check("ch1_filt_latency", 32'(first), 32'd6);
      repeat (15) step();

      // LEVEL/RISE/FALL/ANY on ch0..3 with a 10-cycle high.
      mode[7:0] = {MODE_ANY, MODE_FALL, MODE_RISE, MODE_LEVEL};
      for (int d = 0; d < ND; d++)
         for (int c = 0; c < 4; c++) begin
            pc[d][c] = 0; ps[d][c] = 0; prev[d][c] = pl[d][c];
         end
      async_in[3:0] = 4'hF;
      for (int k = 0; k < 30; k++) begin
         if (k == 10) async_in[3:0] = 4'h0;
         step();
         for (int d = 0; d < ND; d++)
            for (int c = 0; c < 4; c++) begin
               if (pl[d][c] === 1'b1) pc[d][c]++;
               if (pl[d][c] === 1'b1 && !prev[d][c]) ps[d][c]++;
               prev[d][c] = pl[d][c];
            end
      end
      for (int d = 0; d < ND; d++)
         for (int c = 0; c < 4; c++) begin
            check($sformatf("mode_pulse_cycles_d%0d_ch%0d", d, c), 32'(pc[d][c]), 32'(exp_pulses[c]));
            check($sformatf("mode_pulse_count_d%0d_ch%0d", d, c),  32'(ps[d][c]), 32'(exp_pulses[c]));
         end
      mode = {W{MODE_RISE}};
      repeat (15) step();

      // Sticky: set beats clear, then clear alone, then clear with no pulse.
      async_in[4] = 1'b1;
      step();
      step();
      check("stk_pulse",     32'(pl[0][4]), 32'h1);
      check("stk_pre",       32'(st[0][4]), 32'h0);
      sticky_clr[4] = 1'b1;
      step();
      check("stk_set_wins",  32'(st[0][4]), 32'h1);
      step();
      check("stk_cleared",   32'(st[0][4]), 32'h0);
      step();
      check("stk_clr_idle",  32'(st[0][4]), 32'h0);
      sticky_clr = '0;
      async_in[4] = 1'b0;
      repeat (12) step();

      // Input held high through reset on d2 (STAGES=3, FILT_CNT=2).
      async_in[5] = 1'b1;
      rst = 1'b1;
      repeat (3) step();
      check("rsthold_level", 32'(lv[2]), 32'h0);
      check("rsthold_pulse", 32'(pl[2]), 32'h0);
      rst = 1'b0;
      first = -1;
      pcnt  = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (pl[2][5] === 1'b1) begin
            pcnt++;
            if (first < 0) first = k;
         end
      end
      check("rsthold_rise_latency", 32'(first), 32'd5);
      check("rsthold_pulse_width",  32'(pcnt),  32'd1);

      // Reset in the middle of the falling transition's filter window.
      mode[11:10] = MODE_ANY;
      async_in[5] = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      check("midrst_level",  32'(lv[2]), 32'h0);
      check("midrst_pulse",  32'(pl[2]), 32'h0);
      check("midrst_sticky", 32'(st[2]), 32'h0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         step();
         seen = seen | pl[2][5];
      end
      check("midrst_no_pulse", 32'(seen), 32'h0);

      // Randomised traffic checked cycle-exact by the model.
      for (int it = 0; it < 3000; it++) begin
         if (it % 64 == 0) mode = 16'($urandom);
         for (int c = 0; c < W; c++)
            if ($urandom_range(0, 5) == 0) async_in[c] = ~async_in[c];
         sticky_clr = 8'($urandom & $urandom & $urandom);
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
